// File: rtl/hazard_controller.sv
// Pipeline hazard controller for the 5-stage MIPS core: shadows EX/MEM/WB metadata and drives
// register enables, flush/bubble controls, EX forwarding selects and a saturating stall counter.
module hazard_controller #(
  parameter int unsigned CntW = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            id_valid_i,
  input  logic [4:0]      id_rs_i,
  input  logic [4:0]      id_rt_i,
  input  logic            id_uses_rs_i,
  input  logic            id_uses_rt_i,
  input  logic [4:0]      id_dest_i,
  input  logic            id_reg_write_i,
  input  logic            id_mem_read_i,
  input  logic            id_mem_write_i,
  input  logic            id_jump_i,
  input  logic            ex_branch_taken_i,
  input  logic            mem_ready_i,
  output logic            pc_en_o,
  output logic            if_id_en_o,
  output logic            id_ex_en_o,
  output logic            ex_mem_en_o,
  output logic            mem_wb_en_o,
  output logic            if_id_flush_o,
  output logic            id_ex_bubble_o,
  output logic [1:0]      fwd_a_o,
  output logic [1:0]      fwd_b_o,
  output logic [CntW-1:0] stall_count_o
);

  logic       ex_valid_q, ex_rw_q, ex_mr_q, ex_mw_q;
  logic [4:0] ex_rs_q, ex_rt_q, ex_dest_q;
  logic       mem_valid_q, mem_rw_q, mem_mr_q, mem_mw_q;
  logic [4:0] mem_dest_q;
  logic       wb_valid_q, wb_rw_q;
  logic [4:0] wb_dest_q;
  logic [CntW-1:0] stall_cnt_q, stall_cnt_d;

  logic freeze, branch, load_use, jump;
  logic mem_fwd_ok, wb_fwd_ok;

  assign freeze   = mem_valid_q & (mem_mr_q | mem_mw_q) & ~mem_ready_i;
  assign branch   = ex_valid_q & ex_branch_taken_i;
  assign load_use = id_valid_i & ex_valid_q & ex_mr_q & (ex_dest_q != 5'd0) &
                    ((id_uses_rs_i & (id_rs_i == ex_dest_q)) |
                     (id_uses_rt_i & (id_rt_i == ex_dest_q)));
  assign jump     = id_valid_i & id_jump_i;

  always_comb begin
    pc_en_o        = 1'b1;
    if_id_en_o     = 1'b1;
    id_ex_en_o     = 1'b1;
    ex_mem_en_o    = 1'b1;
    mem_wb_en_o    = 1'b1;
    if_id_flush_o  = 1'b0;
    id_ex_bubble_o = 1'b0;
    if (freeze) begin
      pc_en_o     = 1'b0;
      if_id_en_o  = 1'b0;
      id_ex_en_o  = 1'b0;
      ex_mem_en_o = 1'b0;
      mem_wb_en_o = 1'b0;
    end else if (branch) begin
      if_id_flush_o  = 1'b1;
      id_ex_bubble_o = 1'b1;
    end else if (load_use) begin
      // Hold PC and IF/ID so the dependent instruction (or a deferred jump) replays.
      pc_en_o        = 1'b0;
      if_id_en_o     = 1'b0;
      id_ex_bubble_o = 1'b1;
    end else if (jump) begin
      if_id_flush_o = 1'b1;
    end
  end

  // Loads sitting in MEM have no result yet, so they are excluded from EX/MEM forwarding.
  assign mem_fwd_ok = mem_valid_q & mem_rw_q & ~mem_mr_q & (mem_dest_q != 5'd0);
  assign wb_fwd_ok  = wb_valid_q & wb_rw_q & (wb_dest_q != 5'd0);

  always_comb begin
    fwd_a_o = 2'b00;
    fwd_b_o = 2'b00;
    if (mem_fwd_ok && (mem_dest_q == ex_rs_q))     fwd_a_o = 2'b10;
    else if (wb_fwd_ok && (wb_dest_q == ex_rs_q))  fwd_a_o = 2'b01;
    if (mem_fwd_ok && (mem_dest_q == ex_rt_q))     fwd_b_o = 2'b10;
    else if (wb_fwd_ok && (wb_dest_q == ex_rt_q))  fwd_b_o = 2'b01;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_en_o && (stall_cnt_q != {CntW{1'b1}})) stall_cnt_d = stall_cnt_q + CntW'(1);
  end

  assign stall_count_o = stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_valid_q  <= 1'b0;
      ex_rs_q     <= 5'd0;
      ex_rt_q     <= 5'd0;
      ex_dest_q   <= 5'd0;
      ex_rw_q     <= 1'b0;
      ex_mr_q     <= 1'b0;
      ex_mw_q     <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_dest_q  <= 5'd0;
      mem_rw_q    <= 1'b0;
      mem_mr_q    <= 1'b0;
      mem_mw_q    <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_dest_q   <= 5'd0;
      wb_rw_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      if (!freeze) begin
        wb_valid_q  <= mem_valid_q;
        wb_dest_q   <= mem_dest_q;
        wb_rw_q     <= mem_rw_q;
        mem_valid_q <= ex_valid_q;
        mem_dest_q  <= ex_dest_q;
        mem_rw_q    <= ex_rw_q;
        mem_mr_q    <= ex_mr_q;
        mem_mw_q    <= ex_mw_q;
        if (id_ex_bubble_o) begin
          ex_valid_q <= 1'b0;
          ex_rs_q    <= 5'd0;
          ex_rt_q    <= 5'd0;
          ex_dest_q  <= 5'd0;
          ex_rw_q    <= 1'b0;
          ex_mr_q    <= 1'b0;
          ex_mw_q    <= 1'b0;
        end else begin
          ex_valid_q <= id_valid_i;
          ex_rs_q    <= id_rs_i;
          ex_rt_q    <= id_rt_i;
          ex_dest_q  <= id_dest_i;
          ex_rw_q    <= id_reg_write_i;
          ex_mr_q    <= id_mem_read_i;
          ex_mw_q    <= id_mem_write_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: forwarding, load-use, $0/non-use, branch priority,
// jump, memory freeze and asynchronous reset, checked against hand-computed values.
module tb_hazard_controller;

  logic        clk, rst_n;
  logic        id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, id_mem_write;
  logic        id_jump, ex_branch_taken, mem_ready;
  logic [4:0]  id_rs, id_rt, id_dest;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_bubble;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_count;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_controller #(.CntW(16)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .id_valid_i        (id_valid),
    .id_rs_i           (id_rs),
    .id_rt_i           (id_rt),
    .id_uses_rs_i      (id_uses_rs),
    .id_uses_rt_i      (id_uses_rt),
    .id_dest_i         (id_dest),
    .id_reg_write_i    (id_reg_write),
    .id_mem_read_i     (id_mem_read),
    .id_mem_write_i    (id_mem_write),
    .id_jump_i         (id_jump),
    .ex_branch_taken_i (ex_branch_taken),
    .mem_ready_i       (mem_ready),
    .pc_en_o           (pc_en),
    .if_id_en_o        (if_id_en),
    .id_ex_en_o        (id_ex_en),
    .ex_mem_en_o       (ex_mem_en),
    .mem_wb_en_o       (mem_wb_en),
    .if_id_flush_o     (if_id_flush),
    .id_ex_bubble_o    (id_ex_bubble),
    .fwd_a_o           (fwd_a),
    .fwd_b_o           (fwd_b),
    .stall_count_o     (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [4:0] ens = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // valid, rs, rt, uses_rs, uses_rt, dest, reg_write, mem_read, mem_write, jump
  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] dest,
                        input logic rw, input logic mr, input logic mw, input logic j);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_dest = dest; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_jump = j;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    ex_branch_taken = 1'b0;
    mem_ready = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("rst_cnt",    stall_count, 0);
    check("rst_fwd_a",  fwd_a, 2'b00);
    check("rst_fwd_b",  fwd_b, 2'b00);
    check("rst_ens",    ens, 5'b11111);
    check("rst_flush",  if_id_flush, 0);
    check("rst_bubble", id_ex_bubble, 0);
    rst_n = 1'b1;
    step();

    // ALU dependence: add $3 ; sub $6,$3,$4
    set_id(1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
    step();
    set_id(1, 3, 4, 1, 1, 6, 1, 0, 0, 0);
    check("alu_nostall", ens, 5'b11111);
    step();
    check("alu_fwd_a10", fwd_a, 2'b10);
    check("alu_fwd_b00", fwd_b, 2'b00);
    set_id(1, 1, 2, 1, 1, 7, 1, 0, 0, 0);
    step();
    set_id(1, 9, 9, 1, 1, 8, 1, 0, 0, 0);
    step();
    set_id(1, 7, 9, 1, 1, 0, 0, 0, 0, 0);
    step();
    check("gap_fwd_a01", fwd_a, 2'b01);
    check("gap_fwd_b00", fwd_b, 2'b00);

    // Load-use: lw $5 ; add $10,$2,$5
    set_id(1, 1, 0, 1, 0, 5, 1, 1, 0, 0);
    step();
    set_id(1, 2, 5, 1, 1, 10, 1, 0, 0, 0);
    check("lu_ens",    ens, 5'b00111);
    check("lu_bubble", id_ex_bubble, 1);
    check("lu_flush",  if_id_flush, 0);
    check("lu_cnt0",   stall_count, 0);
    step();
    check("lu_cnt1",   stall_count, 1);
    check("lu_resume", ens, 5'b11111);
    step();
    check("lu_fwd_b01", fwd_b, 2'b01);
    check("lu_fwd_a00", fwd_a, 2'b00);

    // $0 writer (ALU) then $0 reader
    set_id(1, 1, 2, 1, 1, 0, 1, 0, 0, 0);
    step();
    set_id(1, 0, 0, 1, 1, 12, 1, 0, 0, 0);
    step();
    check("z_fwd_a", fwd_a, 2'b00);
    check("z_fwd_b", fwd_b, 2'b00);
    // lw $0 followed by $0 reader: no stall
    set_id(1, 1, 0, 1, 0, 0, 1, 1, 0, 0);
    step();
    set_id(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    check("z_lu_ens",    ens, 5'b11111);
    check("z_lu_bubble", id_ex_bubble, 0);
    step();
    // lw $11 followed by reader whose rt=$11 is unused
    set_id(1, 1, 0, 1, 0, 11, 1, 1, 0, 0);
    step();
    set_id(1, 3, 11, 1, 0, 0, 0, 0, 0, 0);
    check("nu_ens",    ens, 5'b11111);
    check("nu_bubble", id_ex_bubble, 0);
    step();
    check("ld_in_mem_nofwd", fwd_b, 2'b00);

    // Branch taken while load-use is true
    set_id(1, 1, 0, 1, 0, 13, 1, 1, 0, 0);
    step();
    set_id(1, 0, 13, 0, 1, 14, 1, 0, 0, 0);
    ex_branch_taken = 1'b1;
    #1;
    check("br_ens",    ens, 5'b11111);
    check("br_flush",  if_id_flush, 1);
    check("br_bubble", id_ex_bubble, 1);
    step();
    ex_branch_taken = 1'b0;
    check("br_cnt", stall_count, 1);

    // Jump
    set_id(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("j_ens",    ens, 5'b11111);
    check("j_flush",  if_id_flush, 1);
    check("j_bubble", id_ex_bubble, 0);
    step();

    // Memory freeze: add $15 ; sw ; reader of $15, then mem_ready low 3 cycles
    set_id(1, 1, 2, 1, 1, 15, 1, 0, 0, 0);
    step();
    set_id(1, 1, 2, 1, 1, 0, 0, 0, 1, 0);
    step();
    set_id(1, 15, 15, 1, 1, 16, 1, 0, 0, 0);
    step();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("fz_ens",    ens, 5'b00000);
      check("fz_flush",  if_id_flush, 0);
      check("fz_bubble", id_ex_bubble, 0);
      check("fz_fwd_a",  fwd_a, 2'b01);
      step();
    end
    mem_ready = 1'b1;
    #1;
    check("fz_resume", ens, 5'b11111);
    check("fz_cnt",    stall_count, 4);
    check("fz_hold_b", fwd_b, 2'b01);
    step();

    // Async reset during a load-use stall
    set_id(1, 1, 0, 1, 0, 17, 1, 1, 0, 0);
    step();
    set_id(1, 0, 17, 0, 1, 18, 1, 0, 0, 0);
    check("ar_stall", pc_en, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_cnt",   stall_count, 0);
    check("ar_fwd_a", fwd_a, 2'b00);
    check("ar_fwd_b", fwd_b, 2'b00);
    check("ar_ens_id", ens, 5'b11111);
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("ar_ens",    ens, 5'b11111);
    check("ar_flush",  if_id_flush, 0);
    check("ar_bubble", id_ex_bubble, 0);
    rst_n = 1'b1;
    set_id(1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
    step();
    set_id(1, 3, 0, 1, 0, 4, 1, 0, 0, 0);
    check("post_rst_ens", ens, 5'b11111);
    step();
    check("post_rst_fwd", fwd_a, 2'b10);
    check("post_rst_cnt", stall_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
